// File: rtl/uart_rx.sv
// 8-bit UART receiver: start, 8 data LSB first, parity, 1 or 2 stop bits; mid-bit sampling.
// Byte and error flags are held until acknowledged; a new frame overwrites them and flags overrun.
module uart_rx #(
  parameter int BAUD_DIVISOR = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic       two_stop,
  input  logic       odd_parity,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  localparam logic [13:0] DIV_M1  = 14'(BAUD_DIVISOR - 1);
  localparam logic [13:0] HALF_M1 = 14'(BAUD_DIVISOR / 2 - 1);

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [13:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        cfg_two_q, cfg_two_d;
  logic        cfg_odd_q, cfg_odd_d;
  logic        perr_acc_q, perr_acc_d;
  logic        ferr_acc_q, ferr_acc_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_err_q, overrun_err_d;

  logic rx_s, half_tick, bit_tick, frame_done;

  assign rx_s      = sync2_q;
  assign half_tick = (cnt_q == HALF_M1);
  assign bit_tick  = (cnt_q == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      cfg_two_q     <= 1'b0;
      cfg_odd_q     <= 1'b0;
      perr_acc_q    <= 1'b0;
      ferr_acc_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= rx_in;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      cfg_two_q     <= cfg_two_d;
      cfg_odd_q     <= cfg_odd_d;
      perr_acc_q    <= perr_acc_d;
      ferr_acc_q    <= ferr_acc_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && bit_q == 3'd7) state_d = PARITY;
      PARITY:  if (bit_tick) state_d = STOP1;
      STOP1:   if (bit_tick) state_d = cfg_two_q ? STOP2 : IDLE;
      STOP2:   if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q + 14'd1;
    bit_d         = bit_q;
    shift_d       = shift_q;
    cfg_two_d     = cfg_two_q;
    cfg_odd_d     = cfg_odd_q;
    perr_acc_d    = perr_acc_q;
    ferr_acc_d    = ferr_acc_q;
    frame_done    = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    overrun_err_d = overrun_err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Config is latched at the start edge so mid-frame changes cannot disturb this frame
        if (!rx_s) begin
          cfg_two_d  = two_stop;
          cfg_odd_d  = odd_parity;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      START: if (half_tick) cnt_d = '0;
      DATA: if (bit_tick) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      PARITY: if (bit_tick) begin
        cnt_d      = '0;
        perr_acc_d = ((^shift_q) ^ rx_s) != cfg_odd_q;
      end
      STOP1: if (bit_tick) begin
        cnt_d      = '0;
        ferr_acc_d = ferr_acc_q | ~rx_s;
        frame_done = ~cfg_two_q;
      end
      STOP2: if (bit_tick) begin
        cnt_d      = '0;
        ferr_acc_d = ferr_acc_q | ~rx_s;
        frame_done = 1'b1;
      end
      default: cnt_d = '0;
    endcase

    // A completing frame beats a coincident ack; overrun only if the old byte was never taken
    if (frame_done) begin
      rx_data_d     = shift_q;
      parity_err_d  = perr_acc_q;
      frame_err_d   = ferr_acc_q | ~rx_s;
      rx_valid_d    = 1'b1;
      overrun_err_d = rx_valid_q & ~rx_ack;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d    = 1'b0;
      overrun_err_d = 1'b0;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIVISOR, default 868, clk cycles per bit (legal range 8..16383, 14-bit counter).
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port two_stop  input  1  1 = two stop bits expected, 0 = one.
REQ-006 SHALL have port odd_parity  input  1  1 = odd parity, 0 = even parity.
REQ-007 SHALL have port rx_ack  input  1  consumer acknowledge, clears rx_valid.
REQ-008 SHALL have port rx_data  output  8  received byte, LSB first on line.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 SHALL have port parity_err  output  1  parity mismatch on the held byte.
REQ-011 SHALL have port frame_err  output  1  stop bit sampled low on the held byte.
REQ-012 SHALL have port overrun_err  output  1  frame completed while rx_valid was high; sticky until rx_ack.

Function
REQ-013 Frame: start (0), 8 data bits LSB first, 1 parity bit, 1 or 2 stop bits (1).
REQ-014 rx_in SHALL pass through a 2-flop synchronizer; all decisions use synchronized rx_s.
REQ-015 FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-016 IDLE: rx_s==0 -> START, baud counter cleared, two_stop and odd_parity captured into internal config register.
REQ-017 START: after BAUD_DIVISOR/2 clocks sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (false start, no output change).
REQ-018 DATA: sample every BAUD_DIVISOR clocks; shift sample in at MSB, shift right; after 8th sample -> PARITY.
REQ-019 PARITY: after BAUD_DIVISOR clocks sample; error when XOR(data, parity sample) != odd_parity; -> STOP1.
REQ-020 STOP1: after BAUD_DIVISOR clocks sample; captured two_stop=1 -> STOP2, else frame complete -> IDLE.
REQ-021 STOP2: after BAUD_DIVISOR clocks sample; frame complete -> IDLE.
REQ-022 frame_err SHALL be set if any stop sample is 0; byte still delivered.
REQ-023 On frame complete, next cycle: rx_data, parity_err, frame_err load; rx_valid=1.
REQ-024 Frame complete with rx_valid already 1 and no rx_ack that cycle: rx_data/errors overwritten with new frame, overrun_err=1.
REQ-025 rx_ack while rx_valid=1 clears rx_valid and overrun_err next cycle; rx_ack with rx_valid=0 ignored.
REQ-026 rx_ack coincident with frame-complete load: new byte wins, rx_valid stays 1, overrun_err not set.
REQ-027 Line low in IDLE after frame (break) SHALL be treated as a new start.
REQ-028 Config inputs changed mid-frame SHALL not affect the frame in progress.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counters 0, synchronizer flops 1, rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0.
REQ-030 Reset mid-frame SHALL abandon the frame; no partial byte delivered after release.

Verification (BAUD_DIVISOR=16)
REQ-031 Send 8'hA5, even parity (bit 0), one stop -> rx_data=8'hA5, rx_valid=1, all errors 0, ~10.5 bit times after start edge.
REQ-032 Send 8'h3C, odd parity, wrong parity bit 0 -> rx_data=8'h3C, parity_err=1, frame_err=0.
REQ-033 two_stop=1, send 8'h81 with second stop bit 0 -> rx_data=8'h81, frame_err=1.
REQ-034 Low glitch of 4 clocks in IDLE -> no rx_valid, FSM back to IDLE.
REQ-035 Send 8'h11 then 8'h22 without rx_ack -> rx_data=8'h22, overrun_err=1; rx_ack -> rx_valid=0, overrun_err=0.
REQ-036 Assert rst_n low during DATA of 8'hFF -> all outputs 0 immediately; next clean 8'h5A frame received correctly.
